// File: rtl/alu_issue_ctrl_if.sv
// Issue-side, ALU-side and result-side signals of the ALU issue controller.
// The controller uses the slave view; the environment uses the master view.
interface alu_issue_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [63:0]      in_a;
  logic [63:0]      in_b;
  logic [1:0]       alu_op;
  logic [10:0]      alu_opcode;
  logic [63:0]      alu_a;
  logic [63:0]      alu_b;
  logic [63:0]      alu_result;
  logic             alu_zero;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_result;
  logic             out_zero;
  logic             out_taken;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_cnt;

  modport slave (
    input  in_valid, in_instr, in_a, in_b, alu_result, alu_zero, out_ready,
    output in_ready, alu_op, alu_opcode, alu_a, alu_b,
           out_valid, out_result, out_zero, out_taken, out_illegal, illegal_cnt
  );

  modport master (
    output in_valid, in_instr, in_a, in_b, alu_result, alu_zero, out_ready,
    input  in_ready, alu_op, alu_opcode, alu_a, alu_b,
           out_valid, out_result, out_zero, out_taken, out_illegal, illegal_cnt
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// LEGv8 ALU issue controller: decodes an accepted instruction, drives the ALU for
// one EXEC cycle and holds the captured result until the consumer takes it.
module alu_issue_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  alu_issue_ctrl_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

  logic [1:0]       state_r;
  logic [1:0]       alu_op_r;
  logic [10:0]      alu_opcode_r;
  logic [63:0]      alu_a_r;
  logic [63:0]      alu_b_r;
  logic             cb_r;
  logic             ill_r;
  logic             out_valid_r;
  logic [63:0]      out_result_r;
  logic             out_zero_r;
  logic             out_taken_r;
  logic             out_illegal_r;
  logic [CNT_W-1:0] illegal_cnt_r;

  logic             in_ready_s;
  logic             accept_s;
  logic [1:0]       dec_op_s;
  logic [10:0]      dec_opcode_s;
  logic             dec_cb_s;
  logic             dec_ill_s;

  // Ready when idle, or when the held result is being drained this cycle.
  always_comb begin
    in_ready_s = 1'b0;
    if (state_r == IDLE) begin
      in_ready_s = 1'b1;
    end else if (state_r == HOLD) begin
      in_ready_s = bus.out_ready;
    end else begin
      in_ready_s = 1'b0;
    end
  end

  assign accept_s = bus.in_valid & in_ready_s;

  // Instruction class decode of the offered word.
  always_comb begin
    dec_op_s     = 2'b00;
    dec_opcode_s = 11'd0;
    dec_cb_s     = 1'b0;
    dec_ill_s    = 1'b0;
    case (bus.in_instr[31:21])
      OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR: begin
        dec_op_s     = 2'b10;
        dec_opcode_s = bus.in_instr[31:21];
      end
      OPC_LDUR, OPC_STUR: begin
        dec_op_s     = 2'b00;
        dec_opcode_s = bus.in_instr[31:21];
      end
      default: begin
        if (bus.in_instr[31:24] == OPC_CBZ) begin
          dec_op_s     = 2'b01;
          dec_opcode_s = bus.in_instr[31:21];
          dec_cb_s     = 1'b1;
        end else begin
          dec_ill_s    = 1'b1;
        end
      end
    endcase
  end

  // Control FSM, ALU drive registers, result capture and illegal counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      alu_op_r      <= 2'b00;
      alu_opcode_r  <= 11'd0;
      alu_a_r       <= 64'd0;
      alu_b_r       <= 64'd0;
      cb_r          <= 1'b0;
      ill_r         <= 1'b0;
      out_valid_r   <= 1'b0;
      out_result_r  <= 64'd0;
      out_zero_r    <= 1'b0;
      out_taken_r   <= 1'b0;
      out_illegal_r <= 1'b0;
      illegal_cnt_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r <= EXEC;
          end
        end
        EXEC: begin
          state_r       <= HOLD;
          out_valid_r   <= 1'b1;
          out_result_r  <= ill_r ? 64'd0 : bus.alu_result;
          out_zero_r    <= ill_r ? 1'b0 : bus.alu_zero;
          out_taken_r   <= cb_r & bus.alu_zero;
          out_illegal_r <= ill_r;
          // ALU inputs are only meaningful during EXEC.
          alu_op_r      <= 2'b00;
          alu_opcode_r  <= 11'd0;
          alu_a_r       <= 64'd0;
          alu_b_r       <= 64'd0;
          if (ill_r && (illegal_cnt_r != {CNT_W{1'b1}})) begin
            illegal_cnt_r <= illegal_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= accept_s ? EXEC : IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
      if (accept_s) begin
        alu_op_r     <= dec_op_s;
        alu_opcode_r <= dec_opcode_s;
        alu_a_r      <= dec_ill_s ? 64'd0 : bus.in_a;
        alu_b_r      <= dec_ill_s ? 64'd0 : bus.in_b;
        cb_r         <= dec_cb_s;
        ill_r        <= dec_ill_s;
      end
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.alu_op      = alu_op_r;
  assign bus.alu_opcode  = alu_opcode_r;
  assign bus.alu_a       = alu_a_r;
  assign bus.alu_b       = alu_b_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_result  = out_result_r;
  assign bus.out_zero    = out_zero_r;
  assign bus.out_taken   = out_taken_r;
  assign bus.out_illegal = out_illegal_r;
  assign bus.illegal_cnt = illegal_cnt_r;
endmodule
